// File: rtl/nibble_arb_pkg.sv
// Shared types and defaults for the nibble adder arbiter slice.
package nibble_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Index reached by stepping 'off' places from 'base' in a ring of n entries.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational wrapping priority picker: first set request at or after ptr.
module rr_pick
  import nibble_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic [IDW-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'(wrap_idx(int'(ptr), k, NREQ));
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nibble_add_arbiter.sv
// Round-robin arbiter sharing one registered W-bit adder among NREQ requesters,
// holding each tagged result until the consumer accepts it.
module nibble_add_arbiter
  import nibble_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_carry,
  output logic [IDW-1:0]    res_id,
  output logic [7:0]        ops_done
);

  state_t         state, state_n;
  logic [IDW-1:0] ptr;
  logic [W-1:0]   a_q, b_q;
  logic [IDW-1:0] id_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic            take;
  logic            fin;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*W +: W];
      b_arr[i] = req_b[i*W +: W];
    end
  end

  assign take = (state == IDLE) && any;
  assign fin  = (state == HOLD) && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        // Reset forces IDLE asynchronously; keep grants dark until it is released.
        if (rst_n) req_ready = gnt;
        if (take)  state_n   = EXEC;
      end
      EXEC: state_n = HOLD;
      HOLD: if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and tag registers are reset along with the result, so nothing undefined can ever reach res_*.
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
      res_valid <= 1'b0;
      ptr       <= '0;
      ops_done  <= '0;
    end else begin
      if (take) begin
        a_q  <= a_arr[gnt_idx];
        b_q  <= b_arr[gnt_idx];
        id_q <= gnt_idx;
      end
      if (state == EXEC) begin
        {res_carry, res_sum} <= {1'b0, a_q} + {1'b0, b_q};
        res_id               <= id_q;
        res_valid            <= 1'b1;
      end
      if (fin) begin
        res_valid <= 1'b0;
        // Granted requester drops to lowest priority for the next search.
        ptr       <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        ops_done  <= ops_done + 8'd1;
      end
    end
  end

endmodule
